// File: rtl/mem_trace_out.sv
// mem_trace_out
// Passive observer of the core's data-memory write port. Every write is
// captured as an {address, data} record into a small FIFO and replayed to a
// host as 7-byte frames on a byte-wide valid/ready stream. The core is never
// stalled: records arriving while the buffer is full are dropped and the
// sticky overflow flag is raised.
//
// Frame layout (in transmit order):
//   byte0     address, zero-extended to 8 bits
//   byte1..6  data, zero-extended to 48 bits, most-significant byte first
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mem_we                core memory write enable
//   mem_addr[44:0]        core memory address (low ADDR_W bits captured)
//   mem_data[DATA_W-1:0]  core memory write data
//   out_valid/out_ready   byte stream handshake
//   out_byte[7:0]         current frame byte
//   out_last              final byte of a frame
//   overflow              sticky record-dropped flag
//   ovf_clr               synchronous clear of overflow (a same-edge drop wins)
//   fifo_level            FIFO occupancy, excluding the record being sent
//
// Serializer states:
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | nothing on the stream; loads the FIFO head as soon as present
//   ST_SEND | shift register holds a frame; byte idx_q is on out_byte

module mem_trace_out #(
  parameter int DATA_W = 45,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_we,
  input  logic [44:0]              mem_addr,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_byte,
  output logic                     out_last,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int REC_W = ADDR_W + DATA_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [55:0]       shreg;

  logic [REC_W-1:0]  fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level_q;
  logic              fifo_empty, fifo_full;
  logic              pop, push, drop;
  logic [REC_W-1:0]  head;
  logic [55:0]       head_frame;

  // Upper address bits are intentionally ignored.
  logic              unused_addr;
  assign unused_addr = ^mem_addr[44:ADDR_W];

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LVL_W'(DEPTH));

  // A full FIFO still accepts a record when the serializer frees a slot on
  // the same edge, so a steady stream at the drain rate never drops.
  assign push = mem_we && (!fifo_full || pop);
  assign drop = mem_we && !push;

  assign head       = fifo_mem[rd_ptr];
  assign head_frame = {8'(head[REC_W-1 -: ADDR_W]), 48'(head[DATA_W-1:0])};

  // FIFO storage carries no reset; occupancy is tracked by level_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {mem_addr[ADDR_W-1:0], mem_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      shreg   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (pop) shreg <= head_frame;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          idx_d   = 3'd0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (idx_q != 3'd6) begin
            idx_d = idx_q + 3'd1;
          end else if (!fifo_empty) begin
            // Reload on the last handshake so frames run back-to-back.
            pop   = 1'b1;
            idx_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_valid  = (state_q == ST_SEND);
  assign out_last   = (state_q == ST_SEND) && (idx_q == 3'd6);
  assign fifo_level = level_q;

  always_comb begin
    out_byte = 8'h00;
    if (state_q == ST_SEND) begin
      case (idx_q)
        3'd0:    out_byte = shreg[55:48];
        3'd1:    out_byte = shreg[47:40];
        3'd2:    out_byte = shreg[39:32];
        3'd3:    out_byte = shreg[31:24];
        3'd4:    out_byte = shreg[23:16];
        3'd5:    out_byte = shreg[15:8];
        3'd6:    out_byte = shreg[7:0];
        default: out_byte = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_trace_out.sv
// Testbench for mem_trace_out: directed scenarios with constant expectations
// plus a randomized run checked against a queue-based reference model.

module tb_mem_trace_out;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_we = 1'b0;
  logic [44:0] mem_addr = '0;
  logic [44:0] mem_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        overflow;
  logic        ovf_clr = 1'b0;
  logic [2:0]  fifo_level;

  int errors = 0;
  int checks = 0;

  mem_trace_out #(.DATA_W(45), .ADDR_W(8), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_byte   (out_byte),
    .out_last   (out_last),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  // Frame contents straight from the frame format: 8-bit address, then the
  // data zero-extended to 48 bits.
  function automatic logic [55:0] make_frame(input logic [44:0] a, input logic [44:0] d);
    return {a[7:0], 3'b000, d};
  endfunction

  // Reference model: records waiting in the buffer, and the bytes of the
  // frame currently on the stream.
  logic [55:0] m_fifo[$];
  logic [7:0]  m_bytes[$];
  bit          m_ovf;

  function automatic void model_reset();
    m_fifo.delete();
    m_bytes.delete();
    m_ovf = 1'b0;
  endfunction

  function automatic void model_step();
    bit busy, hs, take, accept;
    logic [55:0] f;
    busy   = (m_bytes.size() > 0);
    hs     = busy && out_ready;
    take   = (m_fifo.size() > 0) && (!busy || (hs && m_bytes.size() == 1));
    accept = mem_we && ((m_fifo.size() < DEPTH) || take);
    if (hs) void'(m_bytes.pop_front());
    if (take) begin
      f = m_fifo.pop_front();
      for (int k = 0; k < 7; k++) m_bytes.push_back(f[55 - 8*k -: 8]);
    end
    if (accept) m_fifo.push_back(make_frame(mem_addr, mem_data));
    if (mem_we && !accept) m_ovf = 1'b1;
    else if (ovf_clr)      m_ovf = 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Bytes that will be accepted at the next rising edge, {last, byte}.
  logic [8:0] hs_log[$];
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) hs_log.push_back({out_last, out_byte});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", out_last); end
    checks++; if (out_byte !== 8'h00) begin errors++; $display("FAIL reset_byte got=%h exp=00", out_byte); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    logic [7:0] exp_b [7];
    exp_b = '{8'h12, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
    out_ready = 1'b1;
    tick(); mem_we = 1'b1; mem_addr = 45'h12; mem_data = 45'h0123_4567_89AB;
    tick(); mem_we = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_latency valid=%b exp=0", out_valid); end
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL single_level got=%0d exp=1", fifo_level); end
    for (int i = 0; i < 7; i++) begin
      tick(); @(negedge clk);
      checks++;
      if ({out_valid, out_last, out_byte} !== {1'b1, (i == 6), exp_b[i]}) begin
        errors++;
        $display("FAIL single_byte%0d got v=%b l=%b b=%h exp v=1 l=%b b=%h", i, out_valid, out_last, out_byte, (i == 6), exp_b[i]);
      end
    end
    tick(); @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_end_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_b [7];
    exp_b = '{8'h12, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
    hs_log.delete();
    out_ready = 1'b1;
    tick(); mem_we = 1'b1; mem_addr = 45'h12; mem_data = 45'h0123_4567_89AB;
    tick(); mem_we = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      out_ready = !(c >= 3 && c <= 7);
      @(negedge clk);
      if (c >= 3 && c <= 7) begin
        checks++;
        if ({out_valid, out_last, out_byte} !== {1'b1, 1'b0, 8'h23}) begin
          errors++;
          $display("FAIL stall_hold c=%0d got v=%b l=%b b=%h exp v=1 l=0 b=23", c, out_valid, out_last, out_byte);
        end
      end
    end
    checks++; if (hs_log.size() != 7) begin errors++; $display("FAIL stall_count got=%0d exp=7", hs_log.size()); end
    for (int i = 0; i < 7 && i < hs_log.size(); i++) begin
      checks++;
      if (hs_log[i] !== {(i == 6), exp_b[i]}) begin
        errors++; $display("FAIL stall_stream%0d got=%h exp=%h", i, hs_log[i], {(i == 6), exp_b[i]});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [44:0] d [3];
    logic [55:0] fr;
    int first, last, nv, maxlvl;
    first = -1; last = -1; nv = 0; maxlvl = 0;
    for (int i = 0; i < 3; i++) d[i] = 45'({$urandom(), $urandom()});
    hs_log.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 36; c++) begin
      tick();
      if (c < 3) begin mem_we = 1'b1; mem_addr = 45'(c + 1); mem_data = d[c]; end
      else mem_we = 1'b0;
      @(negedge clk);
      if (out_valid) begin
        if (first < 0) first = c;
        last = c;
        nv++;
      end
      if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
    end
    checks++; if (nv != 21) begin errors++; $display("FAIL b2b_valid_count got=%0d exp=21", nv); end
    checks++; if (last - first + 1 != 21) begin errors++; $display("FAIL b2b_contiguous span=%0d exp=21", last - first + 1); end
    checks++; if (maxlvl != 2) begin errors++; $display("FAIL b2b_level_peak got=%0d exp=2", maxlvl); end
    checks++; if (hs_log.size() != 21) begin errors++; $display("FAIL b2b_bytes got=%0d exp=21", hs_log.size()); end
    for (int f = 0; f < 3; f++) begin
      fr = make_frame(45'(f + 1), d[f]);
      for (int k = 0; k < 7; k++) begin
        if (7*f + k < hs_log.size()) begin
          checks++;
          if (hs_log[7*f + k] !== {(k == 6), fr[55 - 8*k -: 8]}) begin
            errors++; $display("FAIL b2b_stream f%0d b%0d got=%h exp=%h", f, k, hs_log[7*f + k], {(k == 6), fr[55 - 8*k -: 8]});
          end
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [44:0] d [7];
    logic [55:0] fr;
    for (int i = 0; i < 7; i++) d[i] = 45'({$urandom(), $urandom()});
    hs_log.delete();
    out_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      tick(); mem_we = 1'b1; mem_addr = 45'(c); mem_data = d[c];
    end
    tick(); mem_we = 1'b0;
    @(negedge clk);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level got=%0d exp=4", fifo_level); end
    checks++; if ({out_valid, out_byte} !== {1'b1, 8'h00}) begin errors++; $display("FAIL ovf_head got v=%b b=%h exp v=1 b=00", out_valid, out_byte); end
    tick(); out_ready = 1'b1;
    repeat (45) tick();
    @(negedge clk);
    checks++; if (hs_log.size() != 35) begin errors++; $display("FAIL ovf_drain_bytes got=%0d exp=35", hs_log.size()); end
    for (int f = 0; f < 5; f++) begin
      fr = make_frame(45'(f), d[f]);
      for (int k = 0; k < 7; k++) begin
        if (7*f + k < hs_log.size()) begin
          checks++;
          if (hs_log[7*f + k] !== {(k == 6), fr[55 - 8*k -: 8]}) begin
            errors++; $display("FAIL ovf_stream f%0d b%0d got=%h exp=%h", f, k, hs_log[7*f + k], {(k == 6), fr[55 - 8*k -: 8]});
          end
        end
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    tick(); ovf_clr = 1'b1;
    tick(); ovf_clr = 1'b0;
    @(negedge clk);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_full_pop();
    logic [44:0] d [6];
    logic [55:0] fr;
    bit found;
    for (int i = 0; i < 6; i++) d[i] = 45'({$urandom(), $urandom()});
    hs_log.delete();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick(); mem_we = 1'b1; mem_addr = 45'(8'h20 + c); mem_data = d[c];
    end
    tick(); mem_we = 1'b0;
    @(negedge clk);
    checks++; if ({overflow, fifo_level} !== {1'b0, 3'd4}) begin errors++; $display("FAIL full_pre got ovf=%b lvl=%0d exp ovf=0 lvl=4", overflow, fifo_level); end
    tick(); out_ready = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (out_valid && out_last) found = 1'b1;
      else @(posedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL full_find_last got=timeout exp=last byte within 20 cycles"); end
    if (found) begin mem_we = 1'b1; mem_addr = 45'h25; mem_data = d[5]; end
    tick(); mem_we = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checks++; if ({overflow, fifo_level} !== {1'b0, 3'd4}) begin errors++; $display("FAIL full_pop_accept got ovf=%b lvl=%0d exp ovf=0 lvl=4", overflow, fifo_level); end
    checks++; if ({out_valid, out_byte} !== {1'b1, 8'h21}) begin errors++; $display("FAIL full_pop_next got v=%b b=%h exp v=1 b=21", out_valid, out_byte); end
    tick(); mem_we = 1'b1; mem_addr = 45'h26; ovf_clr = 1'b1;
    tick(); mem_we = 1'b0; ovf_clr = 1'b0;
    @(negedge clk);
    checks++; if ({overflow, fifo_level} !== {1'b1, 3'd4}) begin errors++; $display("FAIL set_wins got ovf=%b lvl=%0d exp ovf=1 lvl=4", overflow, fifo_level); end
    tick(); ovf_clr = 1'b1;
    tick(); ovf_clr = 1'b0; out_ready = 1'b1;
    repeat (50) tick();
    @(negedge clk);
    checks++; if ({out_valid, fifo_level, overflow} !== {1'b0, 3'd0, 1'b0}) begin errors++; $display("FAIL full_drain got v=%b lvl=%0d ovf=%b exp v=0 lvl=0 ovf=0", out_valid, fifo_level, overflow); end
    checks++; if (hs_log.size() != 42) begin errors++; $display("FAIL full_bytes got=%0d exp=42", hs_log.size()); end
    for (int f = 0; f < 6; f++) begin
      fr = make_frame(45'(8'h20 + f), d[f]);
      for (int k = 0; k < 7; k++) begin
        if (7*f + k < hs_log.size()) begin
          checks++;
          if (hs_log[7*f + k] !== {(k == 6), fr[55 - 8*k -: 8]}) begin
            errors++; $display("FAIL full_stream f%0d b%0d got=%h exp=%h", f, k, hs_log[7*f + k], {(k == 6), fr[55 - 8*k -: 8]});
          end
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      tick();
      mem_we    = ($urandom_range(0, 1) == 1);
      mem_addr  = 45'({$urandom(), $urandom()});
      mem_data  = 45'({$urandom(), $urandom()});
      out_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      checks++;
      if (out_valid !== (m_bytes.size() > 0)) begin
        errors++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, (m_bytes.size() > 0));
      end
      if (m_bytes.size() > 0) begin
        checks++;
        if ({out_last, out_byte} !== {(m_bytes.size() == 1), m_bytes[0]}) begin
          errors++; $display("FAIL rnd_byte c=%0d got l=%b b=%h exp l=%b b=%h", c, out_last, out_byte, (m_bytes.size() == 1), m_bytes[0]);
        end
      end
      checks++;
      if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow c=%0d got=%b exp=%b", c, overflow, m_ovf); end
      checks++;
      if (fifo_level !== 3'(m_fifo.size())) begin errors++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, fifo_level, m_fifo.size()); end
    end
    tick(); mem_we = 1'b0; ovf_clr = 1'b0; out_ready = 1'b1;
    repeat (60) tick();
  endtask

  task automatic test_reset_mid_frame();
    logic [44:0] d0;
    logic [55:0] fr;
    d0 = 45'({$urandom(), $urandom()});
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick(); mem_we = 1'b1; mem_addr = 45'(8'h30 + c); mem_data = (c == 0) ? d0 : 45'(c);
    end
    tick(); mem_we = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    fr = make_frame(45'h30, d0);
    checks++; if ({out_valid, out_byte, overflow} !== {1'b1, fr[31:24], 1'b1}) begin
      errors++; $display("FAIL rstmid_pre got v=%b b=%h ovf=%b exp v=1 b=%h ovf=1", out_valid, out_byte, overflow, fr[31:24]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({out_valid, out_last, out_byte} !== {1'b0, 1'b0, 8'h00}) begin
      errors++; $display("FAIL rstmid_out got v=%b l=%b b=%h exp v=0 l=0 b=00", out_valid, out_last, out_byte);
    end
    checks++; if ({fifo_level, overflow} !== {3'd0, 1'b0}) begin
      errors++; $display("FAIL rstmid_state got lvl=%0d ovf=%b exp lvl=0 ovf=0", fifo_level, overflow);
    end
    tick(); tick();
    @(negedge clk);
    #2 rst_n = 1'b1;
    hs_log.delete();
    for (int c = 0; c < 10; c++) begin
      tick(); @(negedge clk);
      checks++;
      if ({out_valid, fifo_level} !== {1'b0, 3'd0}) begin
        errors++; $display("FAIL rstmid_after c=%0d got v=%b lvl=%0d exp v=0 lvl=0", c, out_valid, fifo_level);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_write();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_random();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
